// File: rtl/pcmplay_irq_pkg.sv
// Shared definitions for the PCM-player interrupt controller.
//  - register word addresses of the Avalon-MM slave
//  - bus widths
//  - lowest_set_index(): priority encoder used by the VECTOR register
package pcmplay_irq_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_PENDING  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_FORCE    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_ACTIVE   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_VECTOR   = 3'd5;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_set_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pcmplay_irq_ctrl_if.sv
// Avalon-MM register port of the interrupt controller.
//  address    word address (master -> slave)
//  chipselect slave select  (master -> slave)
//  write_n    active-low write strobe (master -> slave)
//  writedata  write data    (master -> slave)
//  readdata   registered read data, 1-cycle latency (slave -> master)
interface pcmplay_irq_ctrl_if;
    import pcmplay_irq_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pcmplay_irq_src_cell.sv
// One interrupt source: optional 2-flop synchroniser, previous-value flop for
// rising-edge detection, edge latch and software-force bit.
//  clk, reset_n  clock, asynchronous active-low reset
//  irq_i         raw source line
//  edge_sel_i    1 = rising-edge mode, 0 = level mode
//  w1c_i         clear latch and soft bit (a simultaneous set wins)
//  force_i       set soft bit
//  pend_o        pending = latch | soft | level term
//  soft_o        current soft bit (FORCE read-back)
module pcmplay_irq_src_cell #(
    parameter bit SYNC_EN = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_i,
    input  logic edge_sel_i,
    input  logic w1c_i,
    input  logic force_i,
    output logic pend_o,
    output logic soft_o
);

    logic s_s;
    logic edge_s;
    logic prev_q;
    logic latch_q;
    logic latch_d;
    logic soft_q;
    logic soft_d;

    generate
        if (SYNC_EN) begin : g_sync
            logic [1:0] sync_q;
            // Two-flop synchroniser for an asynchronous source line.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= 2'b00;
                end else begin
                    sync_q <= {sync_q[0], irq_i};
                end
            end
            assign s_s = sync_q[1];
        end else begin : g_nosync
            assign s_s = irq_i;
        end
    endgenerate

    // prev resets to 0, so a line already high at reset release counts as one edge.
    assign edge_s = s_s & ~prev_q & edge_sel_i;

    // Next state of latch and soft bit: a set in the same cycle as W1C wins.
    always_comb begin
        latch_d = latch_q;
        soft_d  = soft_q;
        if (edge_s) begin
            latch_d = 1'b1;
        end else if (w1c_i) begin
            latch_d = 1'b0;
        end else begin
            latch_d = latch_q;
        end
        if (force_i) begin
            soft_d = 1'b1;
        end else if (w1c_i) begin
            soft_d = 1'b0;
        end else begin
            soft_d = soft_q;
        end
    end

    // Source state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= 1'b0;
            latch_q <= 1'b0;
            soft_q  <= 1'b0;
        end else begin
            prev_q  <= s_s;
            latch_q <= latch_d;
            soft_q  <= soft_d;
        end
    end

    // The level term bypasses the latch, so W1C cannot clear it.
    assign pend_o = latch_q | soft_q | (s_s & ~edge_sel_i);
    assign soft_o = soft_q;

endmodule

// File: rtl/pcmplay_irq_ctrl.sv
// Interrupt aggregator: captures up to 16 sources into pending bits, masks
// them with ENABLE and drives one registered CPU interrupt.
//  clk, reset_n  clock, asynchronous active-low reset
//  bus           Avalon-MM slave (PENDING/ENABLE/EDGE_SEL/FORCE/ACTIVE/VECTOR)
//  irq_in_i      source lines, active-high (timer on bit 0)
//  irq_o         registered CPU interrupt, active-high
module pcmplay_irq_ctrl
    import pcmplay_irq_pkg::*;
#(
    parameter int          NUM_SRC      = 4,
    parameter logic [15:0] SYNC_MASK    = 16'h0000,
    parameter logic [15:0] EDGE_RESET   = 16'hFFFF,
    parameter logic [15:0] ENABLE_RESET = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    pcmplay_irq_ctrl_if.slave  bus,
    input  logic [NUM_SRC-1:0] irq_in_i,
    output logic               irq_o
);

    // Bits at and above NUM_SRC are tied off: they read 0 and ignore writes.
    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

    logic        wr_s;
    logic        wr_pending_s;
    logic        wr_force_s;
    logic [15:0] pend_s;
    logic [15:0] soft_s;
    logic [15:0] active_s;
    logic [15:0] enable_q;
    logic [15:0] enable_d;
    logic [15:0] edge_sel_q;
    logic [15:0] edge_sel_d;
    logic [15:0] readdata_q;
    logic [15:0] readdata_d;
    logic        irq_q;
    logic        irq_d;

    assign wr_s         = bus.chipselect & ~bus.write_n;
    assign wr_pending_s = wr_s & (bus.address == ADDR_PENDING);
    assign wr_force_s   = wr_s & (bus.address == ADDR_FORCE);

    generate
        for (genvar i = 0; i < 16; i++) begin : g_src
            if (i < NUM_SRC) begin : g_used
                pcmplay_irq_src_cell #(
                    .SYNC_EN (SYNC_MASK[i])
                ) u_cell (
                    .clk        (clk),
                    .reset_n    (reset_n),
                    .irq_i      (irq_in_i[i]),
                    .edge_sel_i (edge_sel_q[i]),
                    .w1c_i      (wr_pending_s & bus.writedata[i]),
                    .force_i    (wr_force_s & bus.writedata[i]),
                    .pend_o     (pend_s[i]),
                    .soft_o     (soft_s[i])
                );
            end else begin : g_unused
                assign pend_s[i] = 1'b0;
                assign soft_s[i] = 1'b0;
            end
        end
    endgenerate

    assign active_s = pend_s & enable_q;

    // Register writes, read mux and interrupt next state.
    always_comb begin
        enable_d   = enable_q;
        edge_sel_d = edge_sel_q;
        readdata_d = 16'h0000;
        irq_d      = |active_s;
        if (wr_s && (bus.address == ADDR_ENABLE)) begin
            enable_d = bus.writedata & SRC_MASK;
        end else begin
            enable_d = enable_q;
        end
        if (wr_s && (bus.address == ADDR_EDGE_SEL)) begin
            edge_sel_d = bus.writedata & SRC_MASK;
        end else begin
            edge_sel_d = edge_sel_q;
        end
        case (bus.address)
            ADDR_PENDING:  readdata_d = pend_s;
            ADDR_ENABLE:   readdata_d = enable_q;
            ADDR_EDGE_SEL: readdata_d = edge_sel_q;
            ADDR_FORCE:    readdata_d = soft_s;
            ADDR_ACTIVE:   readdata_d = active_s;
            ADDR_VECTOR:   readdata_d = {|active_s, 11'h000, lowest_set_index(active_s)};
            default:       readdata_d = 16'h0000;
        endcase
    end

    // Control registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= ENABLE_RESET & SRC_MASK;
            edge_sel_q <= EDGE_RESET & SRC_MASK;
            readdata_q <= 16'h0000;
            irq_q      <= 1'b0;
        end else begin
            enable_q   <= enable_d;
            edge_sel_q <= edge_sel_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_pcmplay_irq_ctrl.sv
module tb_pcmplay_irq_ctrl;
    import pcmplay_irq_pkg::*;

    localparam int          NSRC   = 4;
    localparam logic [15:0] SYNC_M = 16'h0008;
    localparam logic [15:0] EDGE_R = 16'hFFFF;
    localparam logic [15:0] EN_R   = 16'h0005;
    localparam logic [15:0] MASK   = 16'h000F;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NSRC-1:0] irq_in = '0;
    logic            irq;

    pcmplay_irq_ctrl_if bus ();

    pcmplay_irq_ctrl #(
        .NUM_SRC(NSRC), .SYNC_MASK(SYNC_M), .EDGE_RESET(EDGE_R), .ENABLE_RESET(EN_R)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave), .irq_in_i(irq_in), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard: expected outputs after the next rising edge
    logic [15:0] exp_rd_q[$];
    logic        exp_irq_q[$];

    // reference model state
    logic [15:0] m_latch, m_soft, m_en, m_es, m_sprev, m_h1, m_h2;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_latch = 16'h0; m_soft = 16'h0; m_sprev = 16'h0;
        m_h1 = 16'h0; m_h2 = 16'h0;
        m_en = EN_R & MASK; m_es = EDGE_R & MASK;
    endtask

    task automatic model_step(input logic rst, input logic [NSRC-1:0] in, input logic wr,
                              input logic [2:0] addr, input logic [15:0] wd);
        logic [15:0] in16, s, pend, act, rd, rising, w1c, frc;
        int lo;
        if (!rst) begin
            model_reset();
            exp_rd_q.push_back(16'h0);
            exp_irq_q.push_back(1'b0);
            return;
        end
        in16 = 16'(in);
        // synchronised sources see the line as it was two cycles ago
        s    = ((in16 & ~SYNC_M) | (m_h2 & SYNC_M)) & MASK;
        pend = (m_latch | m_soft | (s & ~m_es)) & MASK;
        act  = pend & m_en;
        lo = 0;
        for (int i = 15; i >= 0; i--) if (act[i]) lo = i;
        case (addr)
            3'd0: rd = pend;
            3'd1: rd = m_en;
            3'd2: rd = m_es;
            3'd3: rd = m_soft;
            3'd4: rd = act;
            3'd5: rd = (act != 16'h0) ? (16'h8000 | 16'(lo)) : 16'h0000;
            default: rd = 16'h0000;
        endcase
        exp_rd_q.push_back(rd);
        exp_irq_q.push_back(act != 16'h0);
        w1c = (wr && addr == 3'd0) ? (wd & MASK) : 16'h0;
        frc = (wr && addr == 3'd3) ? (wd & MASK) : 16'h0;
        rising = s & ~m_sprev & m_es;
        m_latch = rising | (m_latch & ~w1c);
        m_soft  = frc | (m_soft & ~w1c);
        if (wr && addr == 3'd1) m_en = wd & MASK;
        if (wr && addr == 3'd2) m_es = wd & MASK;
        m_sprev = s;
        m_h2 = m_h1;
        m_h1 = in16;
    endtask

    // drive one cycle of stimulus on the falling edge and record its expectation
    task automatic cyc(input logic rst, input logic [NSRC-1:0] in, input logic wr,
                       input logic [2:0] addr, input logic [15:0] wd);
        @(negedge clk);
        reset_n = rst;
        irq_in  = in;
        bus.address   = addr;
        bus.writedata = wd;
        if (wr) begin
            bus.chipselect = 1'b1;
            bus.write_n    = 1'b0;
        end else begin
            bus.chipselect = 1'($urandom_range(0, 1));
            bus.write_n    = bus.chipselect ? 1'b1 : 1'($urandom_range(0, 1));
        end
        model_step(rst, in, wr, addr, wd);
        if (!rst) begin
            #1;
            check("reset_irq_now", {15'h0, irq}, 16'h0);
            check("reset_rd_now", bus.readdata, 16'h0);
        end
    endtask

    task automatic rd(input logic [NSRC-1:0] in, input logic [2:0] addr, input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, in, 1'b0, addr, 16'h0);
    endtask

    // monitor: compare DUT outputs against the scoreboard after every rising edge
    always @(posedge clk) begin
        #1;
        if (exp_rd_q.size() > 0) begin
            check("readdata", bus.readdata, exp_rd_q.pop_front());
            check("irq", {15'h0, irq}, {15'h0, exp_irq_q.pop_front()});
        end
    end

    initial begin
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 16'h0;
        model_reset();
        cyc(1'b0, 4'h0, 1'b0, 3'd1, 16'h0);
        cyc(1'b0, 4'h0, 1'b0, 3'd1, 16'h0);
        rd(4'h0, 3'd1, 2);                      // ENABLE reset value
        rd(4'h0, 3'd2, 1);                      // EDGE_SEL reset value

        // edge on source 0, then W1C
        cyc(1'b1, 4'h0, 1'b1, 3'd1, 16'h0001);
        cyc(1'b1, 4'h1, 1'b0, 3'd0, 16'h0);
        rd(4'h0, 3'd0, 3);
        cyc(1'b1, 4'h0, 1'b1, 3'd0, 16'h0001);
        rd(4'h0, 3'd0, 3);

        // level mode on source 1: W1C cannot clear, dropping the line does
        cyc(1'b1, 4'h0, 1'b1, 3'd2, 16'h0000);
        cyc(1'b1, 4'h0, 1'b1, 3'd1, 16'h0002);
        rd(4'h2, 3'd0, 3);
        cyc(1'b1, 4'h2, 1'b1, 3'd0, 16'h0002);
        rd(4'h2, 3'd0, 2);
        rd(4'h0, 3'd0, 3);

        // edge and W1C in the same cycle: set wins
        cyc(1'b1, 4'h0, 1'b1, 3'd2, 16'hFFFF);
        cyc(1'b1, 4'h0, 1'b1, 3'd1, 16'h0004);
        cyc(1'b1, 4'h4, 1'b1, 3'd0, 16'h0004);
        rd(4'h4, 3'd0, 3);
        cyc(1'b1, 4'h0, 1'b1, 3'd0, 16'h000F);
        rd(4'h0, 3'd0, 2);

        // FORCE, ACTIVE and VECTOR
        cyc(1'b1, 4'h0, 1'b1, 3'd3, 16'h000A);
        cyc(1'b1, 4'h0, 1'b1, 3'd1, 16'h0008);
        rd(4'h0, 3'd4, 2);
        rd(4'h0, 3'd5, 2);
        rd(4'h0, 3'd3, 1);
        cyc(1'b1, 4'h0, 1'b1, 3'd1, 16'h0000);
        rd(4'h0, 3'd5, 3);
        cyc(1'b1, 4'h0, 1'b1, 3'd0, 16'h000F);

        // synchronised source 3: four-cycle latency
        cyc(1'b1, 4'h0, 1'b1, 3'd1, 16'h0008);
        cyc(1'b1, 4'h8, 1'b0, 3'd0, 16'h0);
        rd(4'h8, 3'd0, 6);

        // asynchronous reset with an interrupt pending, then ENABLE reads its reset value
        cyc(1'b1, 4'h8, 1'b0, 3'd0, 16'h0);
        cyc(1'b0, 4'h8, 1'b0, 3'd0, 16'h0);
        cyc(1'b0, 4'h0, 1'b0, 3'd1, 16'h0);
        rd(4'h0, 3'd1, 2);
        rd(4'h0, 3'd0, 2);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic          r_rst, r_wr;
            logic [2:0]    r_addr;
            logic [15:0]   r_wd;
            logic [NSRC-1:0] r_in;
            r_rst  = ($urandom_range(0, 299) != 0);
            r_wr   = ($urandom_range(0, 9) < 3);
            r_addr = 3'($urandom_range(0, 7));
            r_wd   = 16'($urandom);
            r_in   = NSRC'($urandom_range(0, 15));
            cyc(r_rst, r_in, r_wr, r_addr, r_wd);
        end

        cyc(1'b1, 4'h0, 1'b0, 3'd0, 16'h0);
        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_rd_q.size() > 0; k++) @(posedge clk);
        #3;
        if (exp_rd_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d entries left expected 0", exp_rd_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
